matrix_keypad_scanner: RTL and testbench

Parametrised ROWS x COLS active-low matrix keypad scanner running entirely in the system clock domain, using a clock-enable tick with no derived clocks. It drives rows low one at a time, synchronises and samples columns, and debounces every key with a per-key N-sample counter. Outputs are a debounced key-state vector, per-key press/release pulses, and a valid/ready event stream buffered in a small FIFO. It replaces the fixed 4x4 scanner in the user-input path.

---
 rtl/matrix_keypad_scanner.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_matrix_keypad_scanner.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_keypad_scanner.sv
// matrix_keypad_scanner
// ROWS x COLS active-low matrix keypad scanner in the system clock domain.
// Drives one row low per slot and samples the synchronised columns mid-slot.
// Each key is debounced with its own sample counter. Changes are reported as
// a debounced state vector, one-clk press/release pulses, and a
// first-word-fall-through event FIFO.
//
// Optional feature macro: KEYPAD_AUTOREPEAT_EN (auto-repeat press events).
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-high
//   en           scan enable; low parks the scan at row 0, state holds
//   col          column sense, active low, asynchronous to clk
//   row          row drive, active low, combinational from the row index
//   key_state    debounced state, index r*COLS+c, 0 = pressed
//   key_press    one-clk pulse on a stable 1->0 transition
//   key_release  one-clk pulse on a stable 0->1 transition
//   evt_valid    FIFO head valid
//   evt_ready    consumer accepts the head when evt_valid & evt_ready
//   evt_code     key index of the head event
//   evt_press    1 = press, 0 = release
//   evt_repeat   1 = auto-repeat press (constant 0 without the macro)
//   evt_overflow sticky flag: an event was dropped on a full FIFO
//   ovf_clr      clears evt_overflow; a same-cycle drop wins
module matrix_keypad_scanner #(
  parameter int unsigned ROWS         = 4,
  parameter int unsigned COLS         = 4,
  parameter int unsigned CLK_DIV      = 60000,
  parameter int unsigned DEBOUNCE     = 2,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned REPEAT_DELAY = 100,
  parameter int unsigned REPEAT_RATE  = 25
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic [COLS-1:0]                col,
  output logic [ROWS-1:0]                row,
  output logic [ROWS*COLS-1:0]           key_state,
  output logic [ROWS*COLS-1:0]           key_press,
  output logic [ROWS*COLS-1:0]           key_release,
  output logic                           evt_valid,
  input  logic                           evt_ready,
  output logic [$clog2(ROWS*COLS)-1:0]   evt_code,
  output logic                           evt_press,
  output logic                           evt_repeat,
  output logic                           evt_overflow,
  input  logic                           ovf_clr
);

  localparam int unsigned KEYS   = ROWS * COLS;
  localparam int unsigned CODE_W = $clog2(KEYS);
  localparam int unsigned IDX_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned CNT_W  = $clog2(CLK_DIV);
  localparam int unsigned DB_W   = $clog2(DEBOUNCE + 1);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned HALF   = CLK_DIV / 2;

  // Column synchroniser
  logic [COLS-1:0] col_meta;
  logic [COLS-1:0] col_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      col_meta <= '1;
      col_sync <= '1;
    end else begin
      col_meta <= col;
      col_sync <= col_meta;
    end
  end

  // Slot counter and row index
  logic [CNT_W-1:0] slot_cnt;
  logic [IDX_W-1:0] row_idx;
  logic             sample;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      slot_cnt <= '0;
      row_idx  <= '0;
    end else if (slot_cnt == CNT_W'(CLK_DIV - 1)) begin
      slot_cnt <= '0;
      row_idx  <= (row_idx == IDX_W'(ROWS - 1)) ? '0 : row_idx + 1'b1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  // Slot count is forced to 0 while disabled, so no sample can occur then
  assign sample = en && (slot_cnt == CNT_W'(HALF));
  assign row    = en ? ~(ROWS'(1) << row_idx) : '1;

  // Debounce next-state for the keys of the row currently driven
  logic [DB_W-1:0]   db_cnt      [KEYS];
  logic [CODE_W-1:0] key_idx     [COLS];
  logic [DB_W-1:0]   row_cnt_nxt [COLS];
  logic [COLS-1:0]   row_press;
  logic [COLS-1:0]   row_rel;

  always_comb begin
    row_press = '0;
    row_rel   = '0;
    for (int c = 0; c < COLS; c++) begin
      key_idx[c]     = CODE_W'(32'(row_idx) * COLS + 32'(c));
      row_cnt_nxt[c] = '0;
      if (col_sync[c] != key_state[key_idx[c]]) begin
        if (db_cnt[key_idx[c]] == DB_W'(DEBOUNCE - 1)) begin
          if (key_state[key_idx[c]]) row_press[c] = 1'b1;
          else                       row_rel[c]   = 1'b1;
        end else begin
          row_cnt_nxt[c] = db_cnt[key_idx[c]] + 1'b1;
        end
      end
    end
  end

  // Pending change mask of the last sampled row, drained lowest column first
  logic [COLS-1:0]  pend;
  logic [COLS-1:0]  pend_press;
  logic [IDX_W-1:0] pend_row;
  logic             emit_hit;
  logic [COL_W-1:0] emit_col;

  always_comb begin
    emit_hit = 1'b0;
    emit_col = '0;
    for (int c = 0; c < COLS; c++) begin
      if (pend[c] && !emit_hit) begin
        emit_hit = 1'b1;
        emit_col = COL_W'(c);
      end
    end
  end

  // Debounced state, pulses and emission mask
  always_ff @(posedge clk) begin
    if (rst) begin
      key_state   <= '1;
      key_press   <= '0;
      key_release <= '0;
      for (int k = 0; k < KEYS; k++) db_cnt[k] <= '0;
      pend        <= '0;
      pend_press  <= '0;
      pend_row    <= '0;
    end else begin
      key_press   <= '0;
      key_release <= '0;
      if (sample) begin
        for (int c = 0; c < COLS; c++) begin
          db_cnt[key_idx[c]] <= row_cnt_nxt[c];
          if (row_press[c]) begin
            key_state[key_idx[c]] <= 1'b0;
            key_press[key_idx[c]] <= 1'b1;
          end
          if (row_rel[c]) begin
            key_state[key_idx[c]]   <= 1'b1;
            key_release[key_idx[c]] <= 1'b1;
          end
        end
        pend       <= row_press | row_rel;
        pend_press <= row_press;
        pend_row   <= row_idx;
      end else if (emit_hit) begin
        pend <= pend & ~(COLS'(1) << emit_col);
      end
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

  logic             trk_valid;
  logic [IDX_W-1:0] trk_row;
  logic [COL_W-1:0] trk_col;
  logic [RPT_W-1:0] trk_frames;
  logic             trk_first;
  logic             rpt_pend;
  logic             new_hit;
  logic [COL_W-1:0] new_col;

  // Highest newly pressed column of the sampled row becomes the tracked key
  always_comb begin
    new_hit = 1'b0;
    new_col = '0;
    for (int c = 0; c < COLS; c++) begin
      if (row_press[c]) begin
        new_hit = 1'b1;
        new_col = COL_W'(c);
      end
    end
  end

  // Repeat tracker: frames are counted at each sample of the tracked row
  always_ff @(posedge clk) begin
    if (rst) begin
      trk_valid  <= 1'b0;
      trk_row    <= '0;
      trk_col    <= '0;
      trk_frames <= '0;
      trk_first  <= 1'b0;
      rpt_pend   <= 1'b0;
    end else begin
      // Repeat leaves the emitter once change events are drained
      if (rpt_pend && !emit_hit) rpt_pend <= 1'b0;
      if (sample) begin
        if (new_hit) begin
          trk_valid  <= 1'b1;
          trk_row    <= row_idx;
          trk_col    <= new_col;
          trk_frames <= '0;
          trk_first  <= 1'b1;
        end else if (trk_valid && (trk_row == row_idx)) begin
          if (row_rel[trk_col]) begin
            trk_valid <= 1'b0;
          end else if (trk_frames == (trk_first ? RPT_W'(REPEAT_DELAY - 1)
                                                : RPT_W'(REPEAT_RATE - 1))) begin
            rpt_pend   <= 1'b1;
            trk_frames <= '0;
            trk_first  <= 1'b0;
          end else begin
            trk_frames <= trk_frames + 1'b1;
          end
        end
      end
    end
  end
`endif

  // Push selection: change events first, then a pending repeat
  logic              push;
  logic [CODE_W-1:0] push_code;
  logic              push_press;
`ifdef KEYPAD_AUTOREPEAT_EN
  logic              push_rpt;
`endif

  always_comb begin
    push       = emit_hit;
    push_code  = CODE_W'(32'(pend_row) * COLS + 32'(emit_col));
    push_press = pend_press[emit_col];
`ifdef KEYPAD_AUTOREPEAT_EN
    push_rpt   = 1'b0;
    if (!emit_hit && rpt_pend) begin
      push       = 1'b1;
      push_code  = CODE_W'(32'(trk_row) * COLS + 32'(trk_col));
      push_press = 1'b1;
      push_rpt   = 1'b1;
    end
`endif
  end

  // Event FIFO, first-word fall-through
  logic [CODE_W-1:0]     fifo_code [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_press;
`ifdef KEYPAD_AUTOREPEAT_EN
  logic [FIFO_DEPTH-1:0] fifo_rpt;
`endif
  logic [PTR_W:0]        wr_ptr;
  logic [PTR_W:0]        rd_ptr;
  logic                  fifo_full;
  logic                  pop;
  logic                  do_push;

  assign evt_valid = (wr_ptr != rd_ptr);
  assign fifo_full = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign pop       = evt_valid && evt_ready;
  // A pop frees the slot the push lands in, so both succeed when full
  assign do_push   = push && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      evt_overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push && !do_push) evt_overflow <= 1'b1;
      else if (ovf_clr)     evt_overflow <= 1'b0;
    end
  end

  // Storage needs no reset; pointers define what is valid
  always_ff @(posedge clk) begin
    if (do_push) begin
      fifo_code[wr_ptr[PTR_W-1:0]]  <= push_code;
      fifo_press[wr_ptr[PTR_W-1:0]] <= push_press;
`ifdef KEYPAD_AUTOREPEAT_EN
      fifo_rpt[wr_ptr[PTR_W-1:0]]   <= push_rpt;
`endif
    end
  end

  assign evt_code  = fifo_code[rd_ptr[PTR_W-1:0]];
  assign evt_press = fifo_press[rd_ptr[PTR_W-1:0]];
`ifdef KEYPAD_AUTOREPEAT_EN
  assign evt_repeat = fifo_rpt[rd_ptr[PTR_W-1:0]];
`else
  // Constant 0; the repeat timing parameters only survive as a sanity term
  localparam bit RPT_CFG_OK = (REPEAT_DELAY >= 1) && (REPEAT_RATE >= 1);
  assign evt_repeat = 1'b0 && RPT_CFG_OK;
`endif

endmodule

// File: tb/tb_matrix_keypad_scanner.sv
// Directed bench for matrix_keypad_scanner (4x4, CLK_DIV=16, DEBOUNCE=2,
// FIFO_DEPTH=4). A keypad model pulls a column low while its key is held
// and the key's row is driven low.
module tb_matrix_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [15:0] key_state;
  logic [15:0] key_press;
  logic [15:0] key_release;
  logic        evt_valid;
  logic        evt_ready;
  logic [3:0]  evt_code;
  logic        evt_press;
  logic        evt_repeat;
  logic        evt_overflow;
  logic        ovf_clr;
  logic [15:0] pressed;

  int checks = 0;
  int errors = 0;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  always #5 clk = ~clk;

  matrix_keypad_scanner #(
    .ROWS(4), .COLS(4), .CLK_DIV(16), .DEBOUNCE(2), .FIFO_DEPTH(4),
    .REPEAT_DELAY(3), .REPEAT_RATE(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .col(col), .row(row),
    .key_state(key_state), .key_press(key_press), .key_release(key_release),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
    .evt_press(evt_press), .evt_repeat(evt_repeat),
    .evt_overflow(evt_overflow), .ovf_clr(ovf_clr)
  );

  // Keypad model
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !row[r]) col[c] = 1'b0;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Move to the first negedge of a new frame (row 0 just driven, slot 0)
  task automatic align();
    bit ok0 = 1'b0;
    bit ok1 = 1'b0;
    for (int i = 0; i < 200 && !ok0; i++) begin
      @(negedge clk);
      if (row == 4'b0111) ok0 = 1'b1;
    end
    for (int i = 0; i < 200 && !ok1; i++) begin
      @(negedge clk);
      if (row == 4'b1110) ok1 = 1'b1;
    end
    if (!(ok0 && ok1)) check("align_timeout", 32'(ok0 && ok1), 32'd1);
  endtask

  // Wait (bounded) for a head event, compare it, then pop it
  task automatic get_evt(input int code, input bit press, input bit rpt);
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (evt_valid === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
    check($sformatf("evt_valid_k%0d", code), 32'(evt_valid), 32'd1);
    if (ok) begin
      check($sformatf("evt_code_k%0d", code), 32'(evt_code), 32'(code));
      check($sformatf("evt_press_k%0d", code), 32'(evt_press), 32'(press));
      check($sformatf("evt_repeat_k%0d", code), 32'(evt_repeat), 32'(rpt));
      evt_ready = 1'b1;
      @(negedge clk);
      evt_ready = 1'b0;
    end
  endtask

  initial begin
    bit exp_rpt;
    rst = 1'b1; en = 1'b1; evt_ready = 1'b0; ovf_clr = 1'b0; pressed = '0;
    run(3);
    rst = 1'b0;

    // Reset state
    check("rst_row", 32'(row), 32'hE);
    check("rst_key_state", 32'(key_state), 32'hFFFF);
    check("rst_key_press", 32'(key_press), 32'h0);
    check("rst_key_release", 32'(key_release), 32'h0);
    check("rst_evt_valid", 32'(evt_valid), 32'h0);
    check("rst_overflow", 32'(evt_overflow), 32'h0);

    // Row cycling, 16 clocks per slot
    run(15); check("row0_last_clk", 32'(row), 32'hE);
    run(1);  check("row1", 32'(row), 32'hD);
    run(16); check("row2", 32'(row), 32'hB);
    run(16); check("row3", 32'(row), 32'h7);
    run(16); check("row_wrap", 32'(row), 32'hE);

    // Scan disable parks rows high, restarts at row 0
    run(20);
    en = 1'b0; run(2);
    check("en0_row", 32'(row), 32'hF);
    check("en0_key_state", 32'(key_state), 32'hFFFF);
    en = 1'b1; run(1);
    check("en1_row", 32'(row), 32'hE);

    // Key 6 press: row 1 samples at clk 25 of each frame
    align(); pressed[6] = 1'b1;
    run(25); check("k6_one_sample", 32'(key_state), 32'hFFFF);
    align(); run(24);
    check("k6_before_flip", 32'(key_state), 32'hFFFF);
    run(1);
    check("k6_pressed", 32'(key_state), 32'hFFBF);
    check("k6_press_pulse", 32'(key_press), 32'h0040);
    run(1);
    check("k6_press_pulse_end", 32'(key_press), 32'h0);
    get_evt(6, 1'b1, 1'b0);

    // Key 6 release
    align(); pressed[6] = 1'b0;
    run(25); check("k6_rel_one_sample", 32'(key_state), 32'hFFBF);
    align(); run(25);
    check("k6_released", 32'(key_state), 32'hFFFF);
    check("k6_release_pulse", 32'(key_release), 32'h0040);
    run(1);
    check("k6_release_pulse_end", 32'(key_release), 32'h0);
    get_evt(6, 1'b0, 1'b0);

    // Alternating one-frame glitches never reach two agreeing samples
    align(); pressed[6] = 1'b1;
    align(); pressed[6] = 1'b0;
    align(); pressed[6] = 1'b1;
    align(); pressed[6] = 1'b0;
    align();
    check("glitch_key_state", 32'(key_state), 32'hFFFF);
    check("glitch_no_evt", 32'(evt_valid), 32'h0);

    // Keys 4 and 7 in the same frame, consumer always ready
    align(); pressed[4] = 1'b1; pressed[7] = 1'b1;
    align(); evt_ready = 1'b1;
    run(25);
    check("k47_state", 32'(key_state), 32'hFF6F);
    check("k47_press", 32'(key_press), 32'h0090);
    run(1);
    check("k47_first_valid", 32'(evt_valid), 32'h1);
    check("k47_first_code", 32'(evt_code), 32'h4);
    check("k47_first_press", 32'(evt_press), 32'h1);
    run(1);
    check("k47_second_valid", 32'(evt_valid), 32'h1);
    check("k47_second_code", 32'(evt_code), 32'h7);
    check("k47_second_press", 32'(evt_press), 32'h1);
    run(1);
    check("k47_drained", 32'(evt_valid), 32'h0);
    evt_ready = 1'b0;
    pressed[4] = 1'b0; pressed[7] = 1'b0;
    align(); align(); align();
    check("k47_released", 32'(key_state), 32'hFFFF);
    get_evt(4, 1'b0, 1'b0);
    get_evt(7, 1'b0, 1'b0);

    // Overflow: six events into a four-entry FIFO
    align(); pressed[3:1] = 3'b111;
    align(); align();
    check("k123_state", 32'(key_state), 32'hFFF1);
    check("k123_no_ovf_yet", 32'(evt_overflow), 32'h0);
    pressed[3:1] = 3'b000;
    align(); align();
    check("k123_released", 32'(key_state), 32'hFFFF);
    check("ovf_set", 32'(evt_overflow), 32'h1);
    get_evt(1, 1'b1, 1'b0);
    get_evt(2, 1'b1, 1'b0);
    get_evt(3, 1'b1, 1'b0);
    get_evt(1, 1'b0, 1'b0);
    check("ovf_drained", 32'(evt_valid), 32'h0);
    check("ovf_sticky", 32'(evt_overflow), 32'h1);
    ovf_clr = 1'b1; run(1); ovf_clr = 1'b0;
    check("ovf_cleared", 32'(evt_overflow), 32'h0);

    // Hold key 0: one press, then repeats at +3/+5/+7 frames when enabled
    align(); pressed[0] = 1'b1;
    align(); align();
    get_evt(0, 1'b1, 1'b0);
    for (int f = 2; f <= 8; f++) begin
      align();
      exp_rpt = AR && (f == 4 || f == 6 || f == 8);
      check($sformatf("hold_frame%0d_valid", f), 32'(evt_valid), 32'(exp_rpt));
      if (exp_rpt) get_evt(0, 1'b1, 1'b1);
    end
    pressed[0] = 1'b0;
    align(); align();
    get_evt(0, 1'b0, 1'b0);
    check("hold_done_empty", 32'(evt_valid), 32'h0);

    // Reset mid-operation flushes queued events and state
    align(); pressed[9] = 1'b1;
    align(); align();
    check("k9_state", 32'(key_state), 32'hFDFF);
    check("k9_queued", 32'(evt_valid), 32'h1);
    pressed[9] = 1'b0;
    rst = 1'b1; run(1); rst = 1'b0;
    check("midrst_evt_valid", 32'(evt_valid), 32'h0);
    check("midrst_key_state", 32'(key_state), 32'hFFFF);
    check("midrst_row", 32'(row), 32'hE);
    run(1);
    check("midrst_key_press", 32'(key_press), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
